// File: rtl/loader_pkg.sv
// Shared types and sizing for the program loader: FSM state encoding,
// default capacity and the width of the word-count header field.
package loader_pkg;

  localparam int MAX_WORDS_DEF = 256;
  localparam int LEN_W         = 16;
  localparam int CNT_W         = 9;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CHECK  = 3'd5,
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

endpackage

// File: rtl/program_loader_if.sv
// Host byte stream, instruction-memory write port and session status.
// Handshake: a byte transfers on a rising clk edge where rx_valid && rx_ready.
interface program_loader_if;
  import loader_pkg::*;

  logic             start;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             cpu_hold;
  logic             busy;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] words_loaded;

  modport master (
    input  start, rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata,
    output cpu_hold, busy, done, error, words_loaded
  );

  modport slave (
    output start, rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata,
    input  cpu_hold, busy, done, error, words_loaded
  );
endinterface

// File: rtl/program_loader_byte_packer.sv
// Big-endian 4-byte assembler: first byte of a word ends up in bits 31:24.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_done
);
  logic [31:0] r_word;
  logic [1:0]  r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_word  <= '0;
      r_count <= '0;
    end else if (i_en) begin
      r_word  <= {r_word[23:0], i_byte};
      r_count <= r_count + 2'd1;
    end
  end

  // High in the same cycle the 4th byte is accepted; the counter wraps to 0.
  assign o_word_done = i_en && (r_count == 2'd3);
  assign o_word      = r_word;
endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed big-endian word image from a byte stream into
// instruction memory while holding the CPU. Optional trailing XOR checksum
// byte is enabled by defining LOADER_CHECKSUM_EN.
import loader_pkg::*;

module program_loader #(
  parameter int          MAX_WORDS = MAX_WORDS_DEF,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  program_loader_if.master  bus,
  output state_t            o_dbg_state
);
  state_t           r_state, w_next;
  logic [7:0]       r_len_hi;
  logic [LEN_W-1:0] r_len;
  logic [CNT_W-1:0] r_words;
  logic [CNT_W-1:0] w_words_inc;
  logic [LEN_W-1:0] w_len_n;
  logic [31:0]      w_addr_sum;
  logic [31:0]      w_word;
  logic             w_hs, w_clear, w_len_hi_we, w_len_we, w_pack_en, w_inc, w_word_done;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       r_checksum;
`endif

  assign bus.rx_ready     = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                            (r_state == S_DATA)
`ifdef LOADER_CHECKSUM_EN
                            || (r_state == S_CHECK)
`endif
                            ;
  assign w_hs             = bus.rx_valid && bus.rx_ready;
  assign bus.mem_we       = (r_state == S_WRITE);
  assign bus.busy         = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERROR);
  assign bus.cpu_hold     = bus.busy;
  assign bus.done         = (r_state == S_DONE);
  assign bus.error        = (r_state == S_ERROR);
  assign bus.words_loaded = r_words;
  assign bus.mem_wdata    = w_word;
  assign w_addr_sum       = BASE_ADDR + {21'd0, r_words, 2'b00};
  assign bus.mem_addr     = {w_addr_sum[31:2], 2'b00};
  assign w_words_inc      = r_words + 9'd1;
  assign w_len_n          = {r_len_hi, bus.rx_data};
  assign o_dbg_state      = r_state;

  byte_packer u_packer (
    .clk         (clk),
    .rst         (reset),
    .i_clear     (w_clear),
    .i_en        (w_pack_en),
    .i_byte      (bus.rx_data),
    .o_word      (w_word),
    .o_word_done (w_word_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_clear     = 1'b0;
    w_len_hi_we = 1'b0;
    w_len_we    = 1'b0;
    w_pack_en   = 1'b0;
    w_inc       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.start) begin
          w_next  = S_LEN_HI;
          w_clear = 1'b1;
        end
      end
      S_LEN_HI: begin
        if (w_hs) begin
          w_next      = S_LEN_LO;
          w_len_hi_we = 1'b1;
        end
      end
      S_LEN_LO: begin
        if (w_hs) begin
          w_len_we = 1'b1;
          if ((w_len_n == '0) || (w_len_n > LEN_W'(MAX_WORDS))) w_next = S_ERROR;
          else                                                  w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_hs) begin
          w_pack_en = 1'b1;
          if (w_word_done) w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        w_inc = 1'b1;
        if ({7'd0, w_words_inc} == r_len) begin
`ifdef LOADER_CHECKSUM_EN
          w_next = S_CHECK;
`else
          w_next = S_DONE;
`endif
        end else begin
          w_next = S_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (w_hs) w_next = (bus.rx_data == r_checksum) ? S_DONE : S_ERROR;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len_hi <= '0;
      r_len    <= '0;
      r_words  <= '0;
    end else begin
      if (w_len_hi_we) r_len_hi <= bus.rx_data;
      if (w_len_we)    r_len    <= w_len_n;
      if (w_clear)     r_words  <= '0;
      else if (w_inc)  r_words  <= w_words_inc;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_checksum <= '0;
    else if (w_clear)   r_checksum <= '0;
    else if (w_pack_en) r_checksum <= r_checksum ^ bus.rx_data;
  end
`endif
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: random and directed load sessions checked against
// a stream-level model; covers LOADER_CHECKSUM_EN when that macro is defined.
module tb_program_loader;
  import loader_pkg::*;

  localparam int          MAXW = 256;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  state_t dbg_state;
  int     checks = 0;
  int     errors = 0;

  program_loader_if ifc ();

  program_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (ifc),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  logic [63:0] exp_q[$];
  logic [63:0] wr_log[$];
  logic [31:0] tx_words[$];
  int          m_n = 0;
  int          m_idx = 0;
  bit          m_exp_we = 1'b0;
  int          gap_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a write is due the cycle after the 4th byte of each data word is accepted.
  always @(negedge clk) begin
    bit hs, nxt;
    if (reset) begin
      m_idx    = 0;
      m_exp_we = 1'b0;
    end else begin
      chk("mem_we", {63'd0, ifc.mem_we}, {63'd0, m_exp_we});
      if (ifc.mem_we) begin
        wr_log.push_back({ifc.mem_addr, ifc.mem_wdata});
        if (exp_q.size() == 0) chk("unexpected_write", {ifc.mem_addr, ifc.mem_wdata}, 64'hx);
        else chk("write_addr_data", {ifc.mem_addr, ifc.mem_wdata}, exp_q.pop_front());
      end
      hs  = ifc.rx_valid && ifc.rx_ready;
      nxt = hs && (m_idx >= 2) && (m_idx < 2 + 4*m_n) && (((m_idx - 2) % 4) == 3);
      if (ifc.start) m_idx = 0;
      else if (hs)   m_idx++;
      m_exp_we = nxt;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    ifc.rx_data  = b;
    ifc.rx_valid = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!ifc.rx_ready && t < 200);
    if (!ifc.rx_ready) chk("rx_ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    ifc.rx_valid = 1'b0;
    ifc.rx_data  = 8'($urandom);
    if (gap_mode == 1)      begin @(posedge clk); #1; end
    else if (gap_mode == 2) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
  endtask

  task automatic run_session(input int n, input bit corrupt, input string name);
    bit          len_ok = (n != 0) && (n <= MAXW);
    bit          exp_ok = len_ok;
    logic [7:0]  cks = 8'h00;
    logic [15:0] hdr = 16'(n);
    int          t = 0;
`ifdef LOADER_CHECKSUM_EN
    exp_ok = len_ok && !corrupt;
`endif
    m_n = len_ok ? n : 0;
    if (len_ok)
      for (int i = 0; i < n; i++) exp_q.push_back({BASE + 32'(4*i), tx_words[i]});
    pulse_start();
    send_byte(hdr[15:8]);
    send_byte(hdr[7:0]);
    if (len_ok) begin
      for (int i = 0; i < n; i++)
        for (int k = 3; k >= 0; k--) begin
          logic [31:0] w = tx_words[i];
          cks ^= w[8*k +: 8];
          send_byte(w[8*k +: 8]);
        end
`ifdef LOADER_CHECKSUM_EN
      send_byte(cks ^ (corrupt ? 8'h01 : 8'h00));
`endif
    end
    while (!(ifc.done || ifc.error) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_done"},  {63'd0, ifc.done},  {63'd0, exp_ok});
    chk({name, "_error"}, {63'd0, ifc.error}, {63'd0, !exp_ok});
    chk({name, "_words_loaded"}, {55'd0, ifc.words_loaded}, 64'(m_n));
    chk({name, "_cpu_hold"}, {63'd0, ifc.cpu_hold}, 64'd0);
    chk({name, "_busy"}, {63'd0, ifc.busy}, 64'd0);
    chk({name, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_rx_ready"},  {63'd0, ifc.rx_ready}, 64'd0);
    chk({name, "_mem_we"},    {63'd0, ifc.mem_we},   64'd0);
    chk({name, "_mem_addr"},  {32'd0, ifc.mem_addr}, {32'd0, BASE});
    chk({name, "_mem_wdata"}, {32'd0, ifc.mem_wdata}, 64'd0);
    chk({name, "_cpu_hold"},  {63'd0, ifc.cpu_hold}, 64'd0);
    chk({name, "_busy"},      {63'd0, ifc.busy},     64'd0);
    chk({name, "_done"},      {63'd0, ifc.done},     64'd0);
    chk({name, "_error"},     {63'd0, ifc.error},    64'd0);
    chk({name, "_words"},     {55'd0, ifc.words_loaded}, 64'd0);
    chk({name, "_state"},     {61'd0, dbg_state},    {61'd0, S_IDLE});
  endtask

  initial begin
    ifc.start = 1'b0; ifc.rx_valid = 1'b0; ifc.rx_data = 8'h00;
    #1 chk_reset_outputs("reset_init");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Two-word image with hand-computed writes.
    tx_words = '{32'h2009_0005, 32'h200A_0005};
    wr_log.delete();
    run_session(2, 1'b0, "two_words");
    chk("two_words_log_size", 64'(wr_log.size()), 64'd2);
    if (wr_log.size() == 2) begin
      chk("two_words_w0", wr_log[0], 64'h0000_0000_2009_0005);
      chk("two_words_w1", wr_log[1], 64'h0000_0004_200A_0005);
    end

    run_session(0, 1'b0, "len_zero");
    run_session(257, 1'b0, "len_too_big");
    tx_words = '{32'hCAFE_F00D};
    run_session(1, 1'b0, "after_error");

    // Valid toggling every cycle.
    gap_mode = 1;
    tx_words = '{32'hA5A5_5A5A};
    wr_log.delete();
    run_session(1, 1'b0, "bubbles");
    chk("bubbles_writes", 64'(wr_log.size()), 64'd1);

    // Random images with random bubbles.
    for (int s = 0; s < 6; s++) begin
      int n = $urandom_range(1, 6);
      gap_mode = $urandom_range(0, 2);
      tx_words.delete();
      for (int i = 0; i < n; i++) tx_words.push_back($urandom);
      run_session(n, 1'b0, $sformatf("random%0d", s));
    end
    gap_mode = 0;

    // Reset after 2 of 4 data bytes.
    m_n = 2;
    pulse_start();
    send_byte(8'h00); send_byte(8'h02); send_byte(8'hDE); send_byte(8'hAD);
    reset = 1'b1;
    #1 chk_reset_outputs("reset_mid_word");
    @(posedge clk); #1 reset = 1'b0;
    tx_words = '{32'h1357_9BDF};
    run_session(1, 1'b0, "after_reset");

    // Reset while the write strobe is up.
    m_n = 1;
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    chk("write_cycle_we", {63'd0, ifc.mem_we}, 64'd1);
    reset = 1'b1;
    #1 chk("reset_in_write_we", {63'd0, ifc.mem_we}, 64'd0);
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    tx_words = '{32'h0BAD_BEEF, 32'h7654_3210};
    run_session(2, 1'b0, "after_write_reset");

`ifdef LOADER_CHECKSUM_EN
    tx_words = '{32'h1234_5678};
    run_session(1, 1'b0, "cks_match");
    tx_words = '{32'h1234_5678};
    run_session(1, 1'b1, "cks_mismatch");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter MAX_WORDS, 256, instruction memory capacity in 32-bit words.
REQ-002 Parameter BASE_ADDR, 32'h0000_0000, byte address of the first written word.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a load session.
REQ-006 rx_data  input  8  incoming byte.
REQ-007 rx_valid  input  1  rx_data valid this cycle.
REQ-008 rx_ready  output  1  loader accepts a byte; transfer occurs when rx_valid && rx_ready.
REQ-009 mem_we  output  1  one-cycle write strobe to instruction memory.
REQ-010 mem_addr  output  32  word-aligned byte address (bits 1:0 always 0).
REQ-011 mem_wdata  output  32  instruction word to write.
REQ-012 cpu_hold  output  1  holds the processor in reset while loading.
REQ-013 busy / done / error  output  1 each  session status.
REQ-014 words_loaded  output  9  count of words written this session.

Function
REQ-015 FSM states SHALL be IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE, ERROR.
REQ-016 IDLE -> LEN_HI on start; start SHALL be ignored in every other state except DONE and ERROR, where it restarts the session.
REQ-017 Stream format SHALL be: 16-bit big-endian word count N, then 4N bytes, each word big-endian (first byte -> bits 31:24).
REQ-018 LEN_LO: if N == 0 or N > MAX_WORDS, SHALL go to ERROR; otherwise DATA.
REQ-019 rx_ready SHALL be 1 only in LEN_HI, LEN_LO, DATA and (if enabled) CHECK.
REQ-020 After the 4th byte of a word, FSM SHALL enter WRITE for exactly one cycle with mem_we=1, rx_ready=0.
REQ-021 mem_addr SHALL equal BASE_ADDR + 4*words_loaded during WRITE; words_loaded increments at end of WRITE.
REQ-022 From WRITE: if words_loaded+1 == N, SHALL go to CHECK (macro on) or DONE; else DATA.
REQ-023 Byte latency: a word accepted on cycle t SHALL be written on cycle t+1.
REQ-024 cpu_hold and busy SHALL be 1 in every state except IDLE, DONE, ERROR.
REQ-025 done SHALL be 1 only in DONE; error only in ERROR; both held until start or reset.
REQ-026 rx_valid gaps (bubbles) SHALL stall the FSM without loss or duplication.

Reset
REQ-027 Asynchronous reset SHALL force IDLE, rx_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=0, busy=0, done=0, error=0, words_loaded=0, checksum=0.
REQ-028 Reset asserted mid-WRITE SHALL deassert mem_we immediately; partially written images are not rolled back.

Configuration
REQ-029 Macro LOADER_CHECKSUM_EN: when defined, one trailing byte SHALL be accepted in CHECK and compared to the XOR of all 4N data bytes; match -> DONE, mismatch -> ERROR.
REQ-030 Without LOADER_CHECKSUM_EN, CHECK SHALL be unreachable, no trailing byte consumed, no checksum register present.

Structure
REQ-031 Shared package loader_pkg SHALL hold the state enum encoding, MAX_WORDS default and LEN field width.
REQ-032 Sub-module byte_packer (4-byte shift register with byte counter and word-complete flag) SHALL be instantiated once.

Verification
REQ-033 Load N=2, bytes 00 02 20 09 00 05 20 0A 00 05 -> writes 0x20090005 @0x0, 0x200A0005 @0x4; done=1, words_loaded=2.
REQ-034 N=0 header -> ERROR after LEN_LO, no mem_we pulse, cpu_hold=0.
REQ-035 N=257 with MAX_WORDS=256 -> ERROR; start pulse then valid stream -> DONE.
REQ-036 rx_valid toggling 1-0-1 every cycle over N=1 -> exactly one write, data intact.
REQ-037 Reset asserted after 2 of 4 data bytes -> all outputs at reset values same cycle; next session writes from BASE_ADDR.
REQ-038 LOADER_CHECKSUM_EN, N=1, word 0x12345678, checksum byte 0x08 -> DONE; byte 0x09 -> ERROR.
